// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared register map, status layout and FSM states for the RS232 Avalon responder
package rs232_pkg;

    localparam logic [4:0] RX_BASE     = 5'h00;
    localparam logic [4:0] TX_BASE     = 5'h04;
    localparam logic [4:0] STATUS_BASE = 5'h08;

    localparam int TX_OK_BIT        = 6;
    localparam int RX_OK_BIT        = 7;
    localparam int RX_UNDERFLOW_BIT = 8;
    localparam int PROTO_ERR_BIT    = 9;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WSTALL
    } state_t;

    function automatic logic [31:0] status_word(input logic proto_err, input logic rx_underflow,
                                                input logic rx_ok, input logic tx_ok);
        logic [31:0] w;
        w                   = '0;
        w[PROTO_ERR_BIT]    = proto_err;
        w[RX_UNDERFLOW_BIT] = rx_underflow;
        w[RX_OK_BIT]        = rx_ok;
        w[TX_OK_BIT]        = tx_ok;
        return w;
    endfunction

endpackage

// File: rtl/rs232_avs_responder_if.sv
// rtl/rs232_avs_responder_if.sv - Avalon-MM register bus between the polling master and the responder
interface rs232_avs_responder_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/rs232_avs_responder_sync_fifo.sv
// rtl/rs232_avs_responder_sync_fifo.sv - single-clock FIFO; pop-then-push keeps a full FIFO full
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a pop frees the head slot this same edge, so a push into a full FIFO is legal then
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/rs232_avs_responder.sv
// rtl/rs232_avs_responder.sv - Avalon-MM slave exposing RX pop, TX push and status over two byte FIFOs
module rs232_avs_responder #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic                      avm_clk,
    input  logic                      avm_rst_n,
    rs232_avs_responder_if.slave      avs,
    input  logic                      rx_in_valid,
    input  logic [7:0]                rx_in_data,
    output logic                      rx_in_ready,
    output logic                      tx_out_valid,
    output logic [7:0]                tx_out_data,
    input  logic                      tx_out_ready
);
    import rs232_pkg::*;

    state_t      state, state_d;
    logic [4:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        is_rd_q, is_rd_d;
    logic        rx_hit_q, rx_hit_d;
    logic [31:0] readdata_d;
    logic        under_q, proto_q;
    logic        under_set, proto_set, sticky_clr;

    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_dout;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic        unused_bits;

    assign unused_bits  = ^{avs.avm_writedata[31:8], rx_count, tx_count};

    assign rx_in_ready  = avm_rst_n && !rx_full;
    assign rx_push      = rx_in_valid && rx_in_ready;
    assign tx_out_valid = avm_rst_n && !tx_empty;
    assign tx_pop       = tx_out_valid && tx_out_ready;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(avm_clk), .resetn(avm_rst_n), .push(rx_push), .pop(rx_pop), .din(rx_in_data),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(avm_clk), .resetn(avm_rst_n), .push(tx_push), .pop(tx_pop), .din(wdata_q),
        .dout(tx_out_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    // read data and status are decided in the request cycle and registered into the ACK cycle
    always_comb begin
        state_d    = state;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_rd_d    = is_rd_q;
        rx_hit_d   = rx_hit_q;
        readdata_d = '0;
        under_set  = 1'b0;
        proto_set  = 1'b0;
        sticky_clr = 1'b0;
        rx_pop     = 1'b0;
        tx_push    = 1'b0;
        unique case (state)
            IDLE: begin
                if (avs.avm_read) begin
                    state_d   = ACK;
                    addr_d    = avs.avm_address;
                    is_rd_d   = 1'b1;
                    rx_hit_d  = 1'b0;
                    proto_set = avs.avm_write;
                    if (avs.avm_address == RX_BASE) begin
                        if (rx_empty) begin
                            under_set = 1'b1;
                        end else begin
                            readdata_d = {24'b0, rx_dout};
                            rx_hit_d   = 1'b1;
                        end
                    end else if (avs.avm_address == STATUS_BASE) begin
                        readdata_d = status_word(proto_q, under_q, !rx_empty, !tx_full);
                        sticky_clr = 1'b1;
                    end
                end else if (avs.avm_write) begin
                    addr_d   = avs.avm_address;
                    wdata_d  = avs.avm_writedata[7:0];
                    is_rd_d  = 1'b0;
                    rx_hit_d = 1'b0;
                    state_d  = (avs.avm_address == TX_BASE && tx_full) ? WSTALL : ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
                rx_pop  = is_rd_q && rx_hit_q;
                tx_push = !is_rd_q && (addr_q == TX_BASE);
            end
            WSTALL: begin
                if (!tx_full) begin
                    state_d = ACK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            state               <= IDLE;
            addr_q              <= '0;
            wdata_q             <= '0;
            is_rd_q             <= 1'b0;
            rx_hit_q            <= 1'b0;
            under_q             <= 1'b0;
            proto_q             <= 1'b0;
            avs.avm_waitrequest <= 1'b1;
            avs.avm_readdata    <= '0;
        end else begin
            state               <= state_d;
            addr_q              <= addr_d;
            wdata_q             <= wdata_d;
            is_rd_q             <= is_rd_d;
            rx_hit_q            <= rx_hit_d;
            under_q             <= (under_q && !sticky_clr) || under_set;
            proto_q             <= (proto_q && !sticky_clr) || proto_set;
            avs.avm_waitrequest <= (state_d != ACK);
            avs.avm_readdata    <= readdata_d;
        end
    end
endmodule

// File: tb/tb_rs232_avs_responder.sv
// tb/tb_rs232_avs_responder.sv - directed and randomized bench against a queue-based register-map model
module tb_rs232_avs_responder;
    localparam int RX_DEPTH = 16;
    localparam int TX_DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rs232_avs_responder_if avs();

    logic       rand_stream;
    logic       d_rx_valid, r_rx_valid, d_tx_ready, r_tx_ready;
    logic [7:0] d_rx_data, r_rx_data;
    logic       rx_in_valid, rx_in_ready, tx_out_valid, tx_out_ready;
    logic [7:0] rx_in_data, tx_out_data;

    assign rx_in_valid  = rand_stream ? r_rx_valid : d_rx_valid;
    assign rx_in_data   = rand_stream ? r_rx_data  : d_rx_data;
    assign tx_out_ready = rand_stream ? r_tx_ready : d_tx_ready;

    rs232_avs_responder #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
        .avm_clk(clk), .avm_rst_n(rst_n), .avs(avs),
        .rx_in_valid(rx_in_valid), .rx_in_data(rx_in_data), .rx_in_ready(rx_in_ready),
        .tx_out_valid(tx_out_valid), .tx_out_data(tx_out_data), .tx_out_ready(tx_out_ready)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    endtask

    // reference model: byte queues plus the expected bus response for the cycle after each edge
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  tx_seen[$];
    logic        collect = 1'b0;
    bit          started = 1'b0;
    logic        m_wait = 1'b1, m_under = 1'b0, m_proto = 1'b0, m_stall = 1'b0;
    logic        m_pop = 1'b0, m_push = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [7:0]  m_wd = '0;

    task automatic model_step();
        bit rx_acc, tx_take, tx_room, do_pop, do_push;
        logic [31:0] st;
        if (!rst_n) begin
            rxq.delete(); txq.delete();
            m_wait = 1'b1; m_rdata = '0; m_under = 1'b0; m_proto = 1'b0;
            m_stall = 1'b0; m_pop = 1'b0; m_push = 1'b0;
            started = 1'b1;
            return;
        end
        rx_acc  = rx_in_valid && (rxq.size() < RX_DEPTH);
        tx_take = tx_out_ready && (txq.size() > 0);
        tx_room = txq.size() < TX_DEPTH;
        do_pop  = 1'b0;
        do_push = 1'b0;
        if (!m_wait) begin
            do_pop = m_pop; do_push = m_push;
            m_wait = 1'b1; m_rdata = '0; m_pop = 1'b0; m_push = 1'b0;
        end else if (m_stall) begin
            if (tx_room) begin m_stall = 1'b0; m_wait = 1'b0; end
        end else if (avs.avm_read) begin
            m_wait = 1'b0; m_rdata = '0; m_pop = 1'b0; m_push = 1'b0;
            if (avs.avm_address == 5'd0) begin
                if (rxq.size() == 0) m_under = 1'b1;
                else begin m_rdata = 32'(rxq[0]); m_pop = 1'b1; end
            end else if (avs.avm_address == 5'd8) begin
                st = 0;
                if (m_proto) st += 32'h200;
                if (m_under) st += 32'h100;
                if (rxq.size() > 0) st += 32'h80;
                if (txq.size() < TX_DEPTH) st += 32'h40;
                m_rdata = st; m_under = 1'b0; m_proto = 1'b0;
            end
            if (avs.avm_write) m_proto = 1'b1;
        end else if (avs.avm_write) begin
            m_rdata = '0; m_pop = 1'b0;
            m_push = (avs.avm_address == 5'd4);
            m_wd = avs.avm_writedata[7:0];
            if (m_push && !tx_room) m_stall = 1'b1;
            else m_wait = 1'b0;
        end
        if (tx_take) void'(txq.pop_front());
        if (do_push) txq.push_back(m_wd);
        if (do_pop) void'(rxq.pop_front());
        if (rx_acc) rxq.push_back(rx_in_data);
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("waitrequest", 32'(avs.avm_waitrequest), 32'(m_wait));
            if (!m_wait) chk("readdata", avs.avm_readdata, m_rdata);
            chk("rx_in_ready", 32'(rx_in_ready), 32'(rst_n && rxq.size() < RX_DEPTH));
            chk("tx_out_valid", 32'(tx_out_valid), 32'(rst_n && txq.size() > 0));
            if (rst_n && txq.size() > 0) chk("tx_out_data", 32'(tx_out_data), 32'(txq[0]));
        end
        if (collect && tx_out_valid && tx_out_ready) tx_seen.push_back(tx_out_data);
        model_step();
    end

    always @(posedge clk) begin
        #1;
        r_rx_valid <= ($urandom_range(0, 1) == 1);
        r_rx_data  <= 8'($urandom);
        r_tx_ready <= ($urandom_range(0, 3) != 0);
    end

    task automatic bus_idle();
        avs.avm_read = 1'b0; avs.avm_write = 1'b0;
    endtask

    task automatic wait_ack(input string name, output logic [31:0] q, output int lat);
        bit done = 1'b0;
        lat = 0; q = '0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (!avs.avm_waitrequest) begin done = 1'b1; q = avs.avm_readdata; end
            else lat++;
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic xfer(input bit rd, input bit wr, input logic [4:0] a, input logic [31:0] d,
                        output logic [31:0] q, output int lat);
        avs.avm_read = rd; avs.avm_write = wr; avs.avm_address = a; avs.avm_writedata = d;
        wait_ack("xfer_ack", q, lat);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] q; int lat;
        xfer(1'b1, 1'b0, a, 32'd0, q, lat);
        chk(name, q, exp);
        chk({name, "_latency"}, 32'(lat), 32'd1);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] q; int lat;
        xfer(1'b0, 1'b1, a, d, q, lat);
        bus_idle();
    endtask

    task automatic rx_send(input logic [7:0] b);
        d_rx_data = b; d_rx_valid = 1'b1;
        @(posedge clk); #1;
        d_rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] q;
        int lat;
        rand_stream = 1'b0;
        d_rx_valid = 1'b0; d_rx_data = '0; d_tx_ready = 1'b0;
        bus_idle(); avs.avm_address = '0; avs.avm_writedata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_waitrequest", 32'(avs.avm_waitrequest), 32'd1);
        chk("rst_readdata", avs.avm_readdata, 32'd0);
        chk("rst_rx_in_ready", 32'(rx_in_ready), 32'd0);
        chk("rst_tx_out_valid", 32'(tx_out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        rd_chk("status_after_reset", 5'h08, 32'h40);
        bus_idle();

        rx_send(8'h12); rx_send(8'h34); rx_send(8'hAB);
        rd_chk("rx_byte0", 5'h00, 32'h12);
        rd_chk("rx_byte1", 5'h00, 32'h34);
        rd_chk("rx_byte2", 5'h00, 32'hAB);
        bus_idle();
        rd_chk("status_rx_drained", 5'h08, 32'h40);
        bus_idle();

        rd_chk("underflow_data", 5'h00, 32'h0);
        bus_idle();
        rd_chk("status_underflow", 5'h08, 32'h140);
        bus_idle();
        rd_chk("status_underflow_cleared", 5'h08, 32'h40);
        bus_idle();

        collect = 1'b1;
        for (int i = 0; i < 16; i++) wr(5'h04, 32'(i));
        avs.avm_write = 1'b1; avs.avm_address = 5'h04; avs.avm_writedata = 32'h99;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tx_full_stall", 32'(avs.avm_waitrequest), 32'd1);
        end
        @(posedge clk); #1; d_tx_ready = 1'b1;
        @(posedge clk); #1; d_tx_ready = 1'b0;
        wait_ack("stall_release", q, lat);
        bus_idle();
        d_tx_ready = 1'b1;
        repeat (24) @(posedge clk);
        #1; d_tx_ready = 1'b0; collect = 1'b0;
        chk("tx_order_count", 32'(tx_seen.size()), 32'd17);
        for (int i = 0; i < tx_seen.size() && i < 17; i++)
            chk("tx_order", 32'(tx_seen[i]), (i < 16) ? 32'(i) : 32'h99);

        for (int i = 0; i < 16; i++) rx_send(8'(8'hA0 + i));
        @(negedge clk);
        chk("rx_full_ready", 32'(rx_in_ready), 32'd0);
        @(posedge clk); #1;
        d_rx_data = 8'h5A; d_rx_valid = 1'b1;
        rd_chk("rx_full_pop", 5'h00, 32'hA0);
        bus_idle();
        @(posedge clk); #1; d_rx_valid = 1'b0;
        @(negedge clk);
        chk("rx_refilled_ready", 32'(rx_in_ready), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            rd_chk("rx_full_order", 5'h00, (i < 15) ? 32'(8'hA1 + i) : 32'h5A);
            bus_idle();
        end

        for (int i = 0; i < 16; i++) wr(5'h04, 32'(8'h40 + i));
        avs.avm_write = 1'b1; avs.avm_address = 5'h04; avs.avm_writedata = 32'h77;
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_stall_waitrequest", 32'(avs.avm_waitrequest), 32'd1);
        chk("rst_stall_tx_valid", 32'(tx_out_valid), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1; bus_idle();
        rd_chk("status_after_stall_reset", 5'h08, 32'h40);
        bus_idle();

        xfer(1'b1, 1'b1, 5'h08, 32'h0, q, lat);
        bus_idle();
        chk("read_write_collision_data", q, 32'h40);
        rd_chk("status_proto_err", 5'h08, 32'h240);
        bus_idle();
        rd_chk("status_proto_cleared", 5'h08, 32'h40);
        bus_idle();

        rand_stream = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int k;
            logic rd, wrq;
            logic [4:0] a;
            k = $urandom_range(0, 9);
            rd = (k <= 5) || (k == 9);
            wrq = (k >= 6);
            case (k)
                0, 1, 2: a = 5'h00;
                3, 4, 9: a = 5'h08;
                6, 7:    a = 5'h04;
                default: a = 5'($urandom);
            endcase
            xfer(rd, wrq, a, $urandom, q, lat);
            bus_idle();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_stream = 1'b0;
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
        $fatal(1, "watchdog");
    end
endmodule
